alu_int_seq: RTL and testbench

ALU_INT_SEQ -- requirements
Module: alu_int_seq

---
 rtl/alu_int_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_alu_int_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_int_seq.sv
// Sequential integer ALU: single-cycle logic/arith ops plus iterative shift-add multiply.
// Define ALU_INT_SEQ_DIV_EN to add the restoring divider (div/divu/rem/remu).
module alu_int_seq #(
  parameter int WORDSIZE        = 64,
  parameter int CYCLES_PER_STEP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  input  logic [9:0]          operation,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out,
  output logic                overflow,
  output logic                illegal
);

  localparam int W     = WORDSIZE;
  localparam int STEPS = W / CYCLES_PER_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int SH_W  = $clog2(W);

  localparam logic [9:0] OP_ADD   = 10'b000_0000000;
  localparam logic [9:0] OP_SUB   = 10'b000_0100000;
  localparam logic [9:0] OP_SLL   = 10'b001_0000000;
  localparam logic [9:0] OP_SLT   = 10'b010_0000000;
  localparam logic [9:0] OP_SLTU  = 10'b011_0000000;
  localparam logic [9:0] OP_XOR   = 10'b100_0000000;
  localparam logic [9:0] OP_SRL   = 10'b101_0000000;
  localparam logic [9:0] OP_SRA   = 10'b101_0100000;
  localparam logic [9:0] OP_OR    = 10'b110_0000000;
  localparam logic [9:0] OP_AND   = 10'b111_0000000;
  localparam logic [9:0] OP_MUL   = 10'b000_0000001;
  localparam logic [9:0] OP_MULHU = 10'b011_0000001;
`ifdef ALU_INT_SEQ_DIV_EN
  localparam logic [9:0] OP_DIV   = 10'b100_0000001;
  localparam logic [9:0] OP_DIVU  = 10'b101_0000001;
  localparam logic [9:0] OP_REM   = 10'b110_0000001;
  localparam logic [9:0] OP_REMU  = 10'b111_0000001;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {K_MUL, K_MULHU, K_DIV, K_DIVU, K_REM, K_REMU} kind_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   out_q, out_d;
  logic           ovf_q, ovf_d;
  logic           ill_q, ill_d;

  // Iterative datapath: acc holds product high half / partial remainder,
  // lo holds multiplier / dividend shifting into the product low half / quotient.
  kind_t          kind_q, kind_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   lo_q, lo_d;
`ifdef ALU_INT_SEQ_DIV_EN
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           qneg_dec, rneg_dec;
  logic [W-1:0]   abs_a, abs_b;
`endif

  logic signed [W-1:0] a_s, b_s;
  logic [W-1:0]   sum, diff, sc_res, opnd_dec, lo_dec, fin;
  logic [SH_W-1:0] shamt;
  logic           sc_ovf, sc_ill, is_iter;
  kind_t          kind_dec;
  logic [W:0]     acc_t, part;
  logic [W-1:0]   lo_t;

  assign a_s   = input_a;
  assign b_s   = input_b;
  assign sum   = input_a + input_b;
  assign diff  = input_a - input_b;
  assign shamt = input_b[SH_W-1:0];

  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    is_iter  = 1'b0;
    kind_dec = K_MUL;
    opnd_dec = input_a;
    lo_dec   = input_b;
`ifdef ALU_INT_SEQ_DIV_EN
    abs_a    = input_a[W-1] ? -input_a : input_a;
    abs_b    = input_b[W-1] ? -input_b : input_b;
    qneg_dec = 1'b0;
    rneg_dec = 1'b0;
`endif
    case (operation)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (input_a[W-1] == input_b[W-1]) && (sum[W-1] != input_a[W-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (input_a[W-1] != input_b[W-1]) && (diff[W-1] != input_a[W-1]);
      end
      OP_SLL:  sc_res = input_a << shamt;
      OP_SLT:  sc_res = {{(W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: sc_res = {{(W-1){1'b0}}, (input_a < input_b)};
      OP_XOR:  sc_res = input_a ^ input_b;
      OP_SRL:  sc_res = input_a >> shamt;
      OP_SRA:  sc_res = a_s >>> shamt;
      OP_OR:   sc_res = input_a | input_b;
      OP_AND:  sc_res = input_a & input_b;
      OP_MUL: begin
        is_iter  = 1'b1;
        kind_dec = K_MUL;
      end
      OP_MULHU: begin
        is_iter  = 1'b1;
        kind_dec = K_MULHU;
      end
`ifdef ALU_INT_SEQ_DIV_EN
      // Signed ops divide magnitudes; a zero divisor keeps the all-ones quotient unsigned.
      OP_DIV: begin
        is_iter  = 1'b1;
        kind_dec = K_DIV;
        opnd_dec = abs_b;
        lo_dec   = abs_a;
        qneg_dec = (input_a[W-1] ^ input_b[W-1]) && (input_b != '0);
      end
      OP_DIVU: begin
        is_iter  = 1'b1;
        kind_dec = K_DIVU;
        opnd_dec = input_b;
        lo_dec   = input_a;
      end
      OP_REM: begin
        is_iter  = 1'b1;
        kind_dec = K_REM;
        opnd_dec = abs_b;
        lo_dec   = abs_a;
        rneg_dec = input_a[W-1];
      end
      OP_REMU: begin
        is_iter  = 1'b1;
        kind_dec = K_REMU;
        opnd_dec = input_b;
        lo_dec   = input_a;
      end
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    acc_t = acc_q;
    lo_t  = lo_q;
    part  = '0;
    for (int k = 0; k < CYCLES_PER_STEP; k++) begin
      if (kind_q == K_MUL || kind_q == K_MULHU) begin
        part  = lo_t[0] ? (acc_t + {1'b0, opnd_q}) : acc_t;
        acc_t = {1'b0, part[W:1]};
        lo_t  = {part[0], lo_t[W-1:1]};
      end
`ifdef ALU_INT_SEQ_DIV_EN
      else begin
        part = {acc_t[W-1:0], lo_t[W-1]};
        lo_t = {lo_t[W-2:0], 1'b0};
        if (part >= {1'b0, opnd_q}) begin
          part    = part - {1'b0, opnd_q};
          lo_t[0] = 1'b1;
        end
        acc_t = part;
      end
`endif
    end
  end

  always_comb begin
    fin = '0;
    case (kind_q)
      K_MUL:   fin = lo_t;
      K_MULHU: fin = acc_t[W-1:0];
`ifdef ALU_INT_SEQ_DIV_EN
      K_DIV, K_DIVU: fin = qneg_q ? -lo_t : lo_t;
      K_REM, K_REMU: fin = rneg_q ? -acc_t[W-1:0] : acc_t[W-1:0];
`endif
      default: fin = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    kind_d  = kind_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
`ifdef ALU_INT_SEQ_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_iter) begin
            state_d = BUSY;
            cnt_d   = '0;
            kind_d  = kind_dec;
            opnd_d  = opnd_dec;
            acc_d   = '0;
            lo_d    = lo_dec;
`ifdef ALU_INT_SEQ_DIV_EN
            qneg_d  = qneg_dec;
            rneg_d  = rneg_dec;
`endif
          end else begin
            state_d = DONE;
            out_d   = sc_res;
            ovf_d   = sc_ovf;
            ill_d   = sc_ill;
          end
        end
      end
      BUSY: begin
        acc_d = acc_t;
        lo_d  = lo_t;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
          out_d   = fin;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  // Datapath contents are only meaningful in BUSY, so they carry no reset.
  always_ff @(posedge clk) begin
    kind_q <= kind_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
    lo_q   <= lo_d;
`ifdef ALU_INT_SEQ_DIV_EN
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
`endif
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_int_seq.sv
// Directed bench for alu_int_seq (WORDSIZE=64, CYCLES_PER_STEP=1) with an
// arithmetic reference model checked every cycle a result is held.
module tb_alu_int_seq;

  localparam logic [9:0] ADD   = 10'b000_0000000;
  localparam logic [9:0] SUB   = 10'b000_0100000;
  localparam logic [9:0] SLL   = 10'b001_0000000;
  localparam logic [9:0] SLT   = 10'b010_0000000;
  localparam logic [9:0] SLTU  = 10'b011_0000000;
  localparam logic [9:0] XOR   = 10'b100_0000000;
  localparam logic [9:0] SRL   = 10'b101_0000000;
  localparam logic [9:0] SRA   = 10'b101_0100000;
  localparam logic [9:0] OR    = 10'b110_0000000;
  localparam logic [9:0] AND   = 10'b111_0000000;
  localparam logic [9:0] MUL   = 10'b000_0000001;
  localparam logic [9:0] MULHU = 10'b011_0000001;
  localparam logic [9:0] DIV   = 10'b100_0000001;
  localparam logic [9:0] DIVU  = 10'b101_0000001;
  localparam logic [9:0] REM   = 10'b110_0000001;
  localparam logic [9:0] REMU  = 10'b111_0000001;
  localparam logic [9:0] BADOP = 10'b010_0000001;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef ALU_INT_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] input_a, input_b;
  logic [9:0]  operation;
  logic        out_valid, out_ready;
  logic [63:0] out;
  logic        overflow, illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fire_cyc = 0;
  bit mon_en = 1'b0;
  bit exp_pending = 1'b0;
  bit ov_prev = 1'b0;
  logic [63:0] exp_out;
  logic        exp_ovf, exp_ill;
  int          exp_lat;
  logic [63:0] res_out;
  logic        res_ovf, res_ill;

  alu_int_seq #(.WORDSIZE(64), .CYCLES_PER_STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: what each op code must yield, from plain integer arithmetic.
  function automatic void model(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic v, output logic il,
                                output int lat);
    logic signed [63:0] sa, sb;
    logic signed [64:0] ea, eb, s, maxs, mins;
    logic [127:0] p;
    sa = a; sb = b;
    ea = {a[63], a}; eb = {b[63], b};
    maxs = 65'sh7FFF_FFFF_FFFF_FFFF;
    mins = -maxs - 65'sd1;
    p = {64'd0, a} * {64'd0, b};
    r = '0; v = 1'b0; il = 1'b0; lat = 1; s = '0;
    case (op)
      ADD:   begin s = ea + eb; r = s[63:0]; v = (s > maxs) || (s < mins); end
      SUB:   begin s = ea - eb; r = s[63:0]; v = (s > maxs) || (s < mins); end
      SLL:   r = a << b[5:0];
      SRL:   r = a >> b[5:0];
      SRA:   r = sa >>> b[5:0];
      SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
      SLTU:  r = (a < b) ? 64'd1 : 64'd0;
      XOR:   r = a ^ b;
      OR:    r = a | b;
      AND:   r = a & b;
      MUL:   begin r = p[63:0];   lat = 65; end
      MULHU: begin r = p[127:64]; lat = 65; end
      DIV, DIVU, REM, REMU: begin
        if (!DIV_EN) il = 1'b1;
        else begin
          lat = 65;
          if (b == 0) r = (op == DIV || op == DIVU) ? ONES : a;
          else if (op == DIV)  r = (a == MINV && b == ONES) ? MINV : sa / sb;
          else if (op == REM)  r = (a == MINV && b == ONES) ? 64'd0 : sa % sb;
          else if (op == DIVU) r = a / b;
          else                 r = a % b;
        end
      end
      default: il = 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_pending) begin
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        if (out_valid) begin
          if (!ov_prev) chk("latency", 64'(cyc - fire_cyc + 1), 64'(exp_lat));
          chk("model_out", out, exp_out);
          chk("model_ovf", 64'(overflow), 64'(exp_ovf));
          chk("model_ill", 64'(illegal), 64'(exp_ill));
        end
      end else begin
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
      end
      if (out_valid && out_ready && exp_pending) begin
        res_out = out; res_ovf = overflow; res_ill = illegal;
        exp_pending = 1'b0;
      end
      if (in_valid && in_ready && !reset) begin
        model(operation, input_a, input_b, exp_out, exp_ovf, exp_ill, exp_lat);
        exp_pending = 1'b1;
        fire_cyc = cyc + 1;
      end
      if (reset) exp_pending = 1'b0;
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    in_valid = 1'b1; operation = op; input_a = a; input_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; operation = ~op; input_a = ~a; input_b = ~b;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: out_valid 0, required 1", nm);
    end
  endtask

  task automatic run(input string nm, input logic [9:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] eo, input logic ev, input logic ei);
    send(op, a, b);
    wait_done(nm);
    @(posedge clk); #1;
    chk({nm, "_out"}, res_out, eo);
    chk({nm, "_ovf"}, 64'(res_ovf), 64'(ev));
    chk({nm, "_ill"}, 64'(res_ill), 64'(ei));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    input_a = '0; input_b = '0; operation = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_flags", {62'd0, overflow, illegal}, 64'd0);
    mon_en = 1'b1;

    run("add_ovf",  ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, MINV, 1'b1, 1'b0);
    run("sub_ovf",  SUB,  MINV, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run("sub",      SUB,  64'd5, 64'd3, 64'd2, 1'b0, 1'b0);
    run("sll",      SLL,  64'd1, 64'h41, 64'd2, 1'b0, 1'b0);
    run("srl",      SRL,  MINV, 64'hFFFF_FFFF_FFFF_FF3F, 64'd1, 1'b0, 1'b0);
    run("sra",      SRA,  MINV, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0);
    run("slt",      SLT,  ONES, 64'd1, 64'd1, 1'b0, 1'b0);
    run("sltu",     SLTU, ONES, 64'd1, 64'd0, 1'b0, 1'b0);
    run("xor",      XOR,  64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1'b0);
    run("or",       OR,   64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1'b0);
    run("and",      AND,  64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0);
    run("mul",      MUL,  ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run("mulhu",    MULHU, ONES, 64'd2, 64'd1, 1'b0, 1'b0);
    run("mul_small", MUL, 64'd3, 64'd5, 64'd15, 1'b0, 1'b0);
    run("mulhu_pow", MULHU, MINV, 64'd4, 64'd2, 1'b0, 1'b0);
    run("bad_op",   BADOP, 64'd9, 64'd9, 64'd0, 1'b0, 1'b1);
`ifdef ALU_INT_SEQ_DIV_EN
    run("div_ovf",  DIV,  MINV, ONES, MINV, 1'b0, 1'b0);
    run("rem_ovf",  REM,  MINV, ONES, 64'd0, 1'b0, 1'b0);
    run("divu_z",   DIVU, 64'd7, 64'd0, ONES, 1'b0, 1'b0);
    run("remu_z",   REMU, 64'd7, 64'd0, 64'd7, 1'b0, 1'b0);
    run("div_neg",  DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    run("rem_neg",  REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0, 1'b0);
    run("div_z",    DIV,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, 1'b0, 1'b0);
    run("rem_z",    REM,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0);
    run("divu_big", DIVU, ONES, 64'd10, 64'h1999_9999_9999_9999, 1'b0, 1'b0);
`else
    run("div_off",  DIV,  64'd7, 64'd2, 64'd0, 1'b0, 1'b1);
    run("remu_off", REMU, 64'd7, 64'd0, 64'd0, 1'b0, 1'b1);
`endif

    // Result held while the consumer stalls; new requests must be ignored.
    out_ready = 1'b0;
    send(ADD, 64'd2, 64'd3);
    wait_done("hold");
    @(posedge clk); #1;
    in_valid = 1'b1; operation = ADD; input_a = 64'd9; input_b = 64'd9;
    repeat (10) @(posedge clk);
    #1;
    chk("hold_out", out, 64'd5);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_release_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of an iterative op discards it.
`ifdef ALU_INT_SEQ_DIV_EN
    send(DIVU, ONES, 64'd3);
`else
    send(MUL, ONES, 64'd3);
`endif
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out", out, 64'd0);
    @(posedge clk); #1;
    run("post_rst_add", ADD, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
